// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair: FSM state encodings
// and the SPI mode constants (mode 0: CPOL=0, CPHA=0).
package spi_pkg;

    localparam int SPI_STATE_W = 3;

    localparam logic [SPI_STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [SPI_STATE_W-1:0] ST_SETUP = 3'd1;
    localparam logic [SPI_STATE_W-1:0] ST_HIGH  = 3'd2;
    localparam logic [SPI_STATE_W-1:0] ST_LOW   = 3'd3;
    localparam logic [SPI_STATE_W-1:0] ST_DONE  = 3'd4;

    // SCK idle level and sampling phase shared with the slave side.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host and SPI-pin bundle of the SPI master. The master modport is the
// controller's view; the slave modport is the view of whatever drives it.
interface spi_master_ctrl_if #(
    parameter int DATAWIDTH_BUS = 8
);
    logic                     SPI_MASTER_start_In;
    logic [DATAWIDTH_BUS-1:0] SPI_MASTER_data_In;
    logic                     SPI_MASTER_MISO_In;
    logic                     SPI_MASTER_SCK_Out;
    logic                     SPI_MASTER_MOSI_Out;
    logic                     SPI_MASTER_SS_OutLow;
    logic                     SPI_MASTER_busy_Out;
    logic                     SPI_MASTER_newData_Out;
    logic [DATAWIDTH_BUS-1:0] SPI_MASTER_data_Out;

    modport master (
        input  SPI_MASTER_start_In,
        input  SPI_MASTER_data_In,
        input  SPI_MASTER_MISO_In,
        output SPI_MASTER_SCK_Out,
        output SPI_MASTER_MOSI_Out,
        output SPI_MASTER_SS_OutLow,
        output SPI_MASTER_busy_Out,
        output SPI_MASTER_newData_Out,
        output SPI_MASTER_data_Out
    );

    modport slave (
        output SPI_MASTER_start_In,
        output SPI_MASTER_data_In,
        output SPI_MASTER_MISO_In,
        input  SPI_MASTER_SCK_Out,
        input  SPI_MASTER_MOSI_Out,
        input  SPI_MASTER_SS_OutLow,
        input  SPI_MASTER_busy_Out,
        input  SPI_MASTER_newData_Out,
        input  SPI_MASTER_data_Out
    );
endinterface

// File: rtl/spi_master_ctrl_baud.sv
// Phase timer for the SPI master. Counts system clocks within one SCK
// phase and flags the last cycle of the phase. The count restarts at every
// phase change and is held at zero while not running. With extend set the
// phase lasts one cycle longer (used for the closing hold phase), which is
// why the counter is one bit wider than CLK_DIV-1 strictly needs.
module spi_master_ctrl_baud #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic extend,
    output logic phase_end
);
    localparam int CNT_W = $clog2(CLK_DIV) + 1;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] limit_s;

    // Terminal count for the current phase and the end-of-phase flag.
    always_comb begin
        limit_s   = extend ? CNT_W'(CLK_DIV) : CNT_W'(CLK_DIV - 1);
        phase_end = run && (cnt_r == limit_s);
    end

    // Phase counter: wraps to zero at each phase change, idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!run || phase_end) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master controller. A single-cycle start with a parallel word
// runs one full-duplex transfer; the received word is published on
// data_Out with a one-cycle newData pulse. All pins are registered.
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB first
// (default MSB first); timing is identical in both builds.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int STATE_SIZE    = 3,
    parameter int CLK_DIV       = 4
) (
    input  logic                SPI_MASTER_CLOCK_50,
    input  logic                SPI_MASTER_RESET_InLow,
    spi_master_ctrl_if.master   spi
);
    localparam int W     = DATAWIDTH_BUS;
    localparam int BIT_W = $clog2(W);

    logic [STATE_SIZE-1:0] state_r;
    logic [STATE_SIZE-1:0] state_next_s;

    logic [W-1:0]     tx_r;
    logic [W-1:0]     rx_r;
    logic [W-1:0]     data_out_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic             sck_r;
    logic             mosi_r;
    logic             ss_n_r;
    logic             busy_r;
    logic             new_data_r;

    logic             accept_s;
    logic             rise_s;
    logic             shift_s;
    logic             finish_s;
    logic             baud_run_s;
    logic             baud_extend_s;
    logic             phase_end_s;
    logic             last_bit_s;

    logic [W-1:0]     tx_shift_s;
    logic [W-1:0]     rx_shift_s;
    logic             mosi_first_s;
    logic             mosi_next_s;

    spi_master_ctrl_baud #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk       (SPI_MASTER_CLOCK_50),
        .rst_n     (SPI_MASTER_RESET_InLow),
        .run       (baud_run_s),
        .extend    (baud_extend_s),
        .phase_end (phase_end_s)
    );

    assign last_bit_s = (bit_cnt_r == BIT_W'(W - 1));

    // Bit-order dependent shift paths; data_Out keeps wire order either way.
    always_comb begin
`ifdef SPI_MASTER_LSB_FIRST_EN
        tx_shift_s   = {1'b0, tx_r[W-1:1]};
        rx_shift_s   = {spi.SPI_MASTER_MISO_In, rx_r[W-1:1]};
        mosi_first_s = spi.SPI_MASTER_data_In[0];
        mosi_next_s  = tx_r[1];
`else
        tx_shift_s   = {tx_r[W-2:0], 1'b0};
        rx_shift_s   = {rx_r[W-2:0], spi.SPI_MASTER_MISO_In};
        mosi_first_s = spi.SPI_MASTER_data_In[W-1];
        mosi_next_s  = tx_r[W-2];
`endif
    end

    // FSM state register.
    always_ff @(posedge SPI_MASTER_CLOCK_50 or negedge SPI_MASTER_RESET_InLow) begin
        if (!SPI_MASTER_RESET_InLow) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and one-cycle datapath strobes.
    always_comb begin
        state_next_s  = state_r;
        accept_s      = 1'b0;
        rise_s        = 1'b0;
        shift_s       = 1'b0;
        finish_s      = 1'b0;
        baud_run_s    = 1'b1;
        baud_extend_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_run_s = 1'b0;
                if (spi.SPI_MASTER_start_In) begin
                    state_next_s = ST_SETUP;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (phase_end_s) begin
                    state_next_s = ST_HIGH;
                    rise_s       = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HIGH: begin
                if (phase_end_s) begin
                    if (last_bit_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_LOW;
                        shift_s      = 1'b1;
                    end
                end else begin
                    state_next_s = ST_HIGH;
                end
            end
            ST_DONE: begin
                // One extra cycle here gives the (2W+1)*CLK_DIV+1 turnaround.
                baud_extend_s = 1'b1;
                if (phase_end_s) begin
                    state_next_s = ST_IDLE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                baud_run_s   = 1'b0;
            end
        endcase
    end

    // Pin and status registers, decoded from the state being entered.
    always_ff @(posedge SPI_MASTER_CLOCK_50 or negedge SPI_MASTER_RESET_InLow) begin
        if (!SPI_MASTER_RESET_InLow) begin
            sck_r      <= SPI_CPOL;
            ss_n_r     <= 1'b1;
            busy_r     <= 1'b0;
            new_data_r <= 1'b0;
        end else begin
            sck_r      <= (state_next_s == ST_HIGH) ? ~SPI_CPOL : SPI_CPOL;
            ss_n_r     <= (state_next_s == ST_IDLE);
            busy_r     <= (state_next_s != ST_IDLE);
            new_data_r <= finish_s;
        end
    end

    // TX shifter, MOSI and bit counter.
    always_ff @(posedge SPI_MASTER_CLOCK_50 or negedge SPI_MASTER_RESET_InLow) begin
        if (!SPI_MASTER_RESET_InLow) begin
            tx_r      <= {W{1'b0}};
            mosi_r    <= 1'b0;
            bit_cnt_r <= {BIT_W{1'b0}};
        end else if (accept_s) begin
            tx_r      <= spi.SPI_MASTER_data_In;
            mosi_r    <= mosi_first_s;
            bit_cnt_r <= {BIT_W{1'b0}};
        end else if (shift_s) begin
            tx_r      <= tx_shift_s;
            mosi_r    <= mosi_next_s;
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end else if (finish_s) begin
            mosi_r    <= 1'b0;
        end else begin
            tx_r      <= tx_r;
        end
    end

    // RX shifter and published word; only a completed word reaches data_Out.
    always_ff @(posedge SPI_MASTER_CLOCK_50 or negedge SPI_MASTER_RESET_InLow) begin
        if (!SPI_MASTER_RESET_InLow) begin
            rx_r       <= {W{1'b0}};
            data_out_r <= {W{1'b0}};
        end else if (accept_s) begin
            rx_r       <= {W{1'b0}};
        end else if (rise_s) begin
            rx_r       <= rx_shift_s;
        end else if (finish_s) begin
            data_out_r <= rx_r;
        end else begin
            rx_r       <= rx_r;
        end
    end

    assign spi.SPI_MASTER_SCK_Out     = sck_r;
    assign spi.SPI_MASTER_MOSI_Out    = mosi_r;
    assign spi.SPI_MASTER_SS_OutLow   = ss_n_r;
    assign spi.SPI_MASTER_busy_Out    = busy_r;
    assign spi.SPI_MASTER_newData_Out = new_data_r;
    assign spi.SPI_MASTER_data_Out    = data_out_r;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: table of transfers against a behavioural SPI
// slave, scoreboarded on newData, plus reset, busy-start, back-to-back and
// CLK_DIV=1 sequences.
module tb_spi_master_ctrl;
    localparam int W    = 8;
    localparam int CD   = 4;
    localparam int LAT  = (2 * W + 1) * CD + 1;
    localparam int LAT1 = (2 * W + 1) * 1 + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_master_ctrl_if #(.DATAWIDTH_BUS(W)) bus ();
    spi_master_ctrl_if #(.DATAWIDTH_BUS(W)) bus1 ();

    spi_master_ctrl #(.DATAWIDTH_BUS(W), .STATE_SIZE(3), .CLK_DIV(CD)) dut (
        .SPI_MASTER_CLOCK_50    (clk),
        .SPI_MASTER_RESET_InLow (rst_n),
        .spi                    (bus)
    );

    spi_master_ctrl #(.DATAWIDTH_BUS(W), .STATE_SIZE(3), .CLK_DIV(1)) dut1 (
        .SPI_MASTER_CLOCK_50    (clk),
        .SPI_MASTER_RESET_InLow (rst_n),
        .spi                    (bus1)
    );

    logic ss, sck, mosi;
    assign ss   = bus.SPI_MASTER_SS_OutLow;
    assign sck  = bus.SPI_MASTER_SCK_Out;
    assign mosi = bus.SPI_MASTER_MOSI_Out;
    assign bus1.SPI_MASTER_MISO_In = 1'b1;

    // ---------------- behavioural SPI slave (mode 0) ----------------
    logic [W-1:0] slv_q[$];
    logic [W-1:0] slv_word = '0;
    logic [W-1:0] slv_rx   = '0;
    logic [W-1:0] slv_last = '0;
    logic         slv_miso;
    int           slv_idx   = 0;
    int           sck_rises = 0;
    int           sck_bad   = 0;
    int           slv_done  = 0;

    // load the next reply word when selected
    always @(negedge ss) begin
        if (slv_q.size() > 0) slv_word = slv_q.pop_front();
    end

    // reply bit index: advances on SCK fall, restarts on deselect
    always @(posedge ss or negedge sck) begin
        if (ss) slv_idx = 0;
        else    slv_idx = slv_idx + 1;
    end

    // reply bit onto MISO
    always_comb begin
        slv_miso = 1'b0;
        if (slv_idx < W) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
            slv_miso = slv_word[slv_idx];
`else
            slv_miso = slv_word[W-1-slv_idx];
`endif
        end
    end
    assign bus.SPI_MASTER_MISO_In = slv_miso;

    // capture MOSI on SCK rise; flag any SCK rise while deselected
    always @(posedge sck or negedge ss) begin
        if (sck) begin
            if (ss) sck_bad = sck_bad + 1;
            else begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                slv_rx = {mosi, slv_rx[W-1:1]};
`else
                slv_rx = {slv_rx[W-2:0], mosi};
`endif
                sck_rises = sck_rises + 1;
            end
        end else begin
            slv_rx    = '0;
            sck_rises = 0;
        end
    end

    // slave "newData": full word seen when deselected
    always @(posedge ss) begin
        if (sck_rises == W) begin
            slv_last = slv_rx;
            slv_done = slv_done + 1;
        end
    end

    // ---------------- checking ----------------
    typedef struct { logic [W-1:0] tx; logic [W-1:0] slv; } vec_t;
    typedef struct { logic [W-1:0] exp_rx; logic [W-1:0] exp_slv; } sb_t;

    vec_t vecs[5];
    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   slv_done_prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [W-1:0] tx, input logic [W-1:0] reply);
        sb_t e;
        e.exp_rx  = reply;
        e.exp_slv = tx;
        sb_q.push_back(e);
        slv_q.push_back(reply);
    endtask

    task automatic sb_check(input int lat);
        sb_t e;
        chk("stray_new_data", (sb_q.size() == 0), 0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("master_rx", bus.SPI_MASTER_data_Out, e.exp_rx);
            chk("slave_rx", slv_last, e.exp_slv);
            chk("slave_new_data", slv_done, slv_done_prev + 1);
            chk("sck_rises", sck_rises, W);
            chk("latency", lat, LAT);
            chk("sck_while_ss_high", sck_bad, 0);
            chk("busy_at_done", bus.SPI_MASTER_busy_Out, 0);
        end
        slv_done_prev = slv_done;
    endtask

    // step negedges until newData; k counts edges after the accepting edge
    task automatic wait_done(input int budget, input bit hold, input int pa, input int pb);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!hold) begin
                bus.SPI_MASTER_start_In = (k == pa) || (k == pb);
                bus.SPI_MASTER_data_In  = W'($urandom);
            end
            if (bus.SPI_MASTER_newData_Out) begin
                sb_check(k);
                got = 1'b1;
                break;
            end
        end
        chk("done_in_budget", got, 1);
    endtask

    task automatic idle_watch(input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (ss !== 1'b1 || sck !== 1'b0 || bus.SPI_MASTER_busy_Out !== 1'b0 ||
                bus.SPI_MASTER_newData_Out !== 1'b0) bad = bad + 1;
        end
        chk("idle_quiet", bad, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first_rise, second_rise, nd_k, rises;
        logic prev_sck, first_mosi, exp_first;

        vecs[0] = '{tx: 8'hA5, slv: 8'h3C};
        vecs[1] = '{tx: 8'hC3, slv: 8'h5A};
        vecs[2] = '{tx: 8'h00, slv: 8'hFF};
        vecs[3] = '{tx: 8'hFF, slv: 8'h00};
        vecs[4] = '{tx: 8'h69, slv: 8'h96};

        bus.SPI_MASTER_start_In  = 1'b0;
        bus.SPI_MASTER_data_In   = '0;
        bus1.SPI_MASTER_start_In = 1'b0;
        bus1.SPI_MASTER_data_In  = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_ss", ss, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", bus.SPI_MASTER_busy_Out, 0);
        chk("rst_new_data", bus.SPI_MASTER_newData_Out, 0);
        chk("rst_data_out", bus.SPI_MASTER_data_Out, 0);
        idle_watch(30);

        // reset in the middle of bit 3
        slv_q.push_back(8'hAA);
        bus.SPI_MASTER_data_In  = 8'h77;
        bus.SPI_MASTER_start_In = 1'b1;
        @(negedge clk);
        bus.SPI_MASTER_start_In = 1'b0;
        for (int k = 0; k < 200 && sck_rises < 4; k++) @(negedge clk);
        chk("reached_bit3", sck_rises, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ss", ss, 1);
        chk("mid_rst_sck", sck, 0);
        chk("mid_rst_busy", bus.SPI_MASTER_busy_Out, 0);
        chk("mid_rst_new_data", bus.SPI_MASTER_newData_Out, 0);
        chk("mid_rst_data_out", bus.SPI_MASTER_data_Out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch(150);
        chk("mid_rst_no_slave_word", slv_done, 0);

        // table of single transfers; data_In scrambled after acceptance
        for (int i = 0; i < 5; i++) begin
            sb_push(vecs[i].tx, vecs[i].slv);
            bus.SPI_MASTER_data_In  = vecs[i].tx;
            bus.SPI_MASTER_start_In = 1'b1;
            wait_done(200, 1'b0, -1, -1);
            chk("ss_after_done", ss, 1);
        end

        // start pulses during bits 2 and 6 are ignored
        sb_push(8'h3C, 8'h96);
        bus.SPI_MASTER_data_In  = 8'h3C;
        bus.SPI_MASTER_start_In = 1'b1;
        wait_done(200, 1'b0, 2 * 2 * CD + 1, 2 * 6 * CD + 1);
        bus.SPI_MASTER_start_In = 1'b0;
        idle_watch(150);

        // start held high: three back-to-back words
        sb_push(8'h01, 8'h3C);
        sb_push(8'h80, 8'hA5);
        sb_push(8'hFF, 8'h81);
        bus.SPI_MASTER_data_In  = 8'h01;
        bus.SPI_MASTER_start_In = 1'b1;
        wait_done(200, 1'b1, -1, -1);
        chk("b2b_ss_gap1", ss, 1);
        bus.SPI_MASTER_data_In = 8'h80;
        wait_done(200, 1'b1, -1, -1);
        chk("b2b_ss_gap2", ss, 1);
        bus.SPI_MASTER_data_In = 8'hFF;
        wait_done(200, 1'b1, -1, -1);
        bus.SPI_MASTER_start_In = 1'b0;
        chk("b2b_ss_gap3", ss, 1);
        idle_watch(20);
        chk("sb_drained", sb_q.size(), 0);

        // CLK_DIV=1 instance, word 0x01, MISO held high
`ifdef SPI_MASTER_LSB_FIRST_EN
        exp_first = 1'b1;
`else
        exp_first = 1'b0;
`endif
        first_rise  = -1;
        second_rise = -1;
        nd_k        = -1;
        rises       = 0;
        first_mosi  = 1'bx;
        bus1.SPI_MASTER_data_In  = 8'h01;
        bus1.SPI_MASTER_start_In = 1'b1;
        @(negedge clk);
        bus1.SPI_MASTER_start_In = 1'b0;
        prev_sck = 1'b0;
        for (int k = 0; k < 60 && nd_k < 0; k++) begin
            if (bus1.SPI_MASTER_SCK_Out && !prev_sck) begin
                rises = rises + 1;
                if (first_rise < 0) begin
                    first_rise = k;
                    first_mosi = bus1.SPI_MASTER_MOSI_Out;
                end else if (second_rise < 0) begin
                    second_rise = k;
                end
            end
            prev_sck = bus1.SPI_MASTER_SCK_Out;
            if (bus1.SPI_MASTER_newData_Out) nd_k = k;
            @(negedge clk);
        end
        chk("div1_first_mosi", first_mosi, exp_first);
        chk("div1_sck_period", second_rise - first_rise, 2);
        chk("div1_sck_rises", rises, W);
        chk("div1_latency", nd_k, LAT1);
        chk("div1_data_out", bus1.SPI_MASTER_data_Out, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
